// File: rtl/alu_exec_unit_pkg.sv
// Shared opcode/function encodings and internal ALU operation codes for the
// execute unit and its decoder.
package alu_exec_unit_pkg;

  localparam logic [3:0] OPCODE_RTYPE = 4'd0;
  localparam logic [3:0] OPCODE_ADI   = 4'd1;
  localparam logic [3:0] OPCODE_ORI   = 4'd2;
  localparam logic [3:0] OPCODE_LHI   = 4'd3;
  localparam logic [3:0] OPCODE_LWD   = 4'd4;
  localparam logic [3:0] OPCODE_SWD   = 4'd5;
  localparam logic [3:0] OPCODE_BNE   = 4'd6;
  localparam logic [3:0] OPCODE_BEQ   = 4'd7;
  localparam logic [3:0] OPCODE_BGZ   = 4'd8;
  localparam logic [3:0] OPCODE_BLZ   = 4'd9;
  localparam logic [3:0] OPCODE_JMP   = 4'd10;
  localparam logic [3:0] OPCODE_JAL   = 4'd11;

  localparam logic [5:0] FUNC_ADD = 6'd0;
  localparam logic [5:0] FUNC_SUB = 6'd1;
  localparam logic [5:0] FUNC_AND = 6'd2;
  localparam logic [5:0] FUNC_ORR = 6'd3;
  localparam logic [5:0] FUNC_NOT = 6'd4;
  localparam logic [5:0] FUNC_TCP = 6'd5;
  localparam logic [5:0] FUNC_SHL = 6'd6;
  localparam logic [5:0] FUNC_SHR = 6'd7;
  localparam logic [5:0] FUNC_MUL = 6'd8;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_NOT   = 4'd4,
    OP_TCP   = 4'd5,
    OP_SHL   = 4'd6,
    OP_SHR   = 4'd7,
    OP_LHI   = 4'd8,
    OP_PASSB = 4'd9,
    OP_PASSA = 4'd10,
    OP_MUL   = 4'd11
  } alu_op_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of opcode/funct into an internal ALU operation.
// Anything unrecognised passes operand a through and flags illegal.
module alu_op_decode
  import alu_exec_unit_pkg::*;
#(
  parameter int MUL_EN = 1
) (
  input  logic [3:0] opcode,
  input  logic [5:0] funct,
  output alu_op_t    op,
  output logic       illegal
);

  always_comb begin
    op      = OP_PASSA;
    illegal = 1'b1;
    case (opcode)
      OPCODE_RTYPE: begin
        illegal = 1'b0;
        case (funct)
          FUNC_ADD: op = OP_ADD;
          FUNC_SUB: op = OP_SUB;
          FUNC_AND: op = OP_AND;
          FUNC_ORR: op = OP_OR;
          FUNC_NOT: op = OP_NOT;
          FUNC_TCP: op = OP_TCP;
          FUNC_SHL: op = OP_SHL;
          FUNC_SHR: op = OP_SHR;
          FUNC_MUL: begin
            if (MUL_EN != 0) begin
              op = OP_MUL;
            end else begin
              illegal = 1'b1;
            end
          end
          default: illegal = 1'b1;
        endcase
      end
      OPCODE_ADI, OPCODE_LWD, OPCODE_SWD: begin
        op      = OP_ADD;
        illegal = 1'b0;
      end
      OPCODE_ORI: begin
        op      = OP_OR;
        illegal = 1'b0;
      end
      OPCODE_LHI: begin
        op      = OP_LHI;
        illegal = 1'b0;
      end
      OPCODE_BNE, OPCODE_BEQ, OPCODE_BGZ, OPCODE_BLZ: begin
        op      = OP_SUB;
        illegal = 1'b0;
      end
      OPCODE_JMP, OPCODE_JAL: begin
        op      = OP_PASSB;
        illegal = 1'b0;
      end
      default: begin
        op      = OP_PASSA;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute unit: single-cycle ALU ops plus a WIDTH-cycle shift-add multiplier,
// with a one-entry registered result and valid/ready handshakes on both sides.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int SHIFT_VAR = 0,
  parameter int MUL_EN    = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_sum;
  logic [SHW-1:0]   count;

  alu_op_t          op;
  logic             dec_illegal;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] shl_out;
  logic [WIDTH-1:0] shr_out;
  logic             accept;

  alu_op_decode #(
    .MUL_EN(MUL_EN)
  ) u_decode (
    .opcode (opcode),
    .funct  (funct),
    .op     (op),
    .illegal(dec_illegal)
  );

  generate
    if (SHIFT_VAR != 0) begin : gen_shift_var
      logic [SHW-1:0] amt;
      assign amt     = b[SHW-1:0];
      assign shl_out = a << amt;
      assign shr_out = $signed(a) >>> amt;
    end else begin : gen_shift_one
      assign shl_out = {a[WIDTH-2:0], 1'b0};
      assign shr_out = {a[WIDTH-1], a[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    alu_out = a;
    case (op)
      OP_ADD:   alu_out = a + b;
      OP_SUB:   alu_out = a - b;
      OP_AND:   alu_out = a & b;
      OP_OR:    alu_out = a | b;
      OP_NOT:   alu_out = ~a;
      OP_TCP:   alu_out = ~a + WIDTH'(1);
      OP_SHL:   alu_out = shl_out;
      OP_SHR:   alu_out = shr_out;
      OP_LHI:   alu_out = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_PASSB: alu_out = b;
      default:  alu_out = a;
    endcase
  end

  // Gating with reset_n keeps the unit closed while reset is held.
  assign in_ready = reset_n &&
                    (((state == ST_IDLE) && !out_valid) ||
                     ((state == ST_HOLD) && out_ready));
  assign accept   = in_valid && in_ready;
  assign acc_sum  = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      illegal   <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      count     <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (accept) begin
            if (op == OP_MUL) begin
              state     <= ST_MUL;
              out_valid <= 1'b0;
              mcand     <= a;
              mplier    <= b;
              acc       <= '0;
              count     <= '0;
            end else begin
              state     <= ST_HOLD;
              out_valid <= 1'b1;
              result    <= alu_out;
              illegal   <= dec_illegal;
            end
          end else if ((state == ST_HOLD) && out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        ST_MUL: begin
          // The last of the WIDTH iterations writes the product directly.
          if (count == SHW'(WIDTH - 1)) begin
            state     <= ST_HOLD;
            out_valid <= 1'b1;
            result    <= acc_sum;
            illegal   <= 1'b0;
          end else begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
